// File: rtl/mac_layer_sequencer_pkg.sv
// Shared state encoding, datapath constants and helpers for the FC-layer MAC sequencer.
package mac_seq_pkg;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        DRAIN,
        OUTPUT
    } seqState_t;

    localparam int LANES = 16;
    localparam int PIX_W = 8;
    localparam int SUM_W = 20;
    localparam int EXT_W = 64;

    // Index width that never collapses to zero bits for single-entry ranges.
    function automatic int idxWidth(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

    function automatic logic signed [EXT_W-1:0] signExtendSum(input logic signed [SUM_W-1:0] s);
        return EXT_W'(s);
    endfunction

endpackage

// File: rtl/mac_layer_sequencer_if.sv
// Buffer-read / mac-return / result-stream bundle between the sequencer and the layer top.
interface mac_layer_sequencer_if
    import mac_seq_pkg::*;
#(
    parameter int NUM_CHUNKS  = 4,
    parameter int NUM_NEURONS = 10,
    parameter int ACC_W       = 24
);
    localparam int PIX_AW = idxWidth(NUM_CHUNKS);
    localparam int WGT_AW = idxWidth(NUM_NEURONS * NUM_CHUNKS);
    localparam int IDX_W  = idxWidth(NUM_NEURONS);

    logic                     rd_en;
    logic [PIX_AW-1:0]        pix_addr;
    logic [WGT_AW-1:0]        wgt_addr;
    logic signed [SUM_W-1:0]  sum_in;
    logic                     out_valid;
    logic                     out_ready;
    logic signed [ACC_W-1:0]  out_data;
    logic [IDX_W-1:0]         out_idx;

    modport master (
        output rd_en, pix_addr, wgt_addr, out_valid, out_data, out_idx,
        input  sum_in, out_ready
    );

    modport slave (
        input  rd_en, pix_addr, wgt_addr, out_valid, out_data, out_idx,
        output sum_in, out_ready
    );

endinterface

// File: rtl/mac_layer_sequencer_valid_pipe.sv
// Shift register tracking reads in flight through buffer + mac; async clear drops stale tokens.
module mac_valid_pipe #(
    parameter int DEPTH = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic vldIn,
    output logic vldTail,
    output logic vldPending
);
    localparam logic [DEPTH-1:0] TAIL_MASK = DEPTH'(1) << (DEPTH - 1);

    logic [DEPTH-1:0] vld_p;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld_p <= '0;
        end else begin
            vld_p <= (vld_p << 1) | DEPTH'(vldIn);
        end
    end

    assign vldTail    = vld_p[DEPTH-1];
    // Tokens still travelling behind the one that is currently at the tail.
    assign vldPending = |(vld_p & ~TAIL_MASK);

endmodule

// File: rtl/mac_layer_sequencer.sv
// Walks neurons and chunks of one FC layer, accumulates mac partial sums, streams neuron results.
module mac_layer_sequencer
    import mac_seq_pkg::*;
#(
    parameter int NUM_CHUNKS  = 4,
    parameter int NUM_NEURONS = 10,
    parameter int MAC_LAT     = 1,
    parameter int ACC_W       = 24,
    parameter bit RELU        = 1'b1
) (
    input  logic clk,
    input  logic rst,
    input  logic start,
    output logic busy,
    output logic done,
    mac_layer_sequencer_if.master bus
);
    localparam int PIX_AW = idxWidth(NUM_CHUNKS);
    localparam int WGT_AW = idxWidth(NUM_NEURONS * NUM_CHUNKS);
    localparam int IDX_W  = idxWidth(NUM_NEURONS);
    localparam logic [PIX_AW-1:0] LAST_CHUNK  = PIX_AW'(NUM_CHUNKS - 1);
    localparam logic [IDX_W-1:0]  LAST_NEURON = IDX_W'(NUM_NEURONS - 1);

    seqState_t                state;
    logic                     rdEn;
    logic [PIX_AW-1:0]        chunk;
    logic [WGT_AW-1:0]        wgtAddr;
    logic [IDX_W-1:0]         neuron;
    logic signed [ACC_W-1:0]  acc;
    logic signed [ACC_W-1:0]  accNext;
    logic signed [ACC_W-1:0]  outData;
    logic                     outValid;
    logic                     vldTail;
    logic                     vldPending;

    function automatic logic signed [ACC_W-1:0] applyRelu(input logic signed [ACC_W-1:0] v);
        return (RELU && (v < 0)) ? '0 : v;
    endfunction

    // Buffer read (1 cycle) plus mac register latency before sum_in is valid.
    mac_valid_pipe #(
        .DEPTH(1 + MAC_LAT)
    ) uValidPipe (
        .clk        (clk),
        .rst        (rst),
        .vldIn      (rdEn),
        .vldTail    (vldTail),
        .vldPending (vldPending)
    );

    always_comb begin
        accNext = acc;
        if (vldTail) begin
            accNext = acc + ACC_W'(signExtendSum(bus.sum_in));
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            busy     <= 1'b0;
            done     <= 1'b0;
            rdEn     <= 1'b0;
            chunk    <= '0;
            wgtAddr  <= '0;
            neuron   <= '0;
            acc      <= '0;
            outData  <= '0;
            outValid <= 1'b0;
        end else begin
            done <= 1'b0;
            acc  <= accNext;
            case (state)
                IDLE: begin
                    if (start) begin
                        state   <= ISSUE;
                        busy    <= 1'b1;
                        rdEn    <= 1'b1;
                        chunk   <= '0;
                        wgtAddr <= '0;
                        neuron  <= '0;
                        acc     <= '0;
                    end
                end
                ISSUE: begin
                    if (chunk == LAST_CHUNK) begin
                        state <= DRAIN;
                        rdEn  <= 1'b0;
                    end else begin
                        chunk   <= chunk + 1'b1;
                        wgtAddr <= wgtAddr + 1'b1;
                    end
                end
                DRAIN: begin
                    // The last partial sum lands on the same edge that exposes the result.
                    if (vldTail && !vldPending && !rdEn) begin
                        state    <= OUTPUT;
                        outValid <= 1'b1;
                        outData  <= applyRelu(accNext);
                    end
                end
                OUTPUT: begin
                    if (bus.out_ready) begin
                        outValid <= 1'b0;
                        if (neuron == LAST_NEURON) begin
                            state <= IDLE;
                            busy  <= 1'b0;
                            done  <= 1'b1;
                        end else begin
                            state   <= ISSUE;
                            rdEn    <= 1'b1;
                            neuron  <= neuron + 1'b1;
                            chunk   <= '0;
                            wgtAddr <= wgtAddr + 1'b1;
                            acc     <= '0;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.rd_en     = rdEn;
    assign bus.pix_addr  = chunk;
    assign bus.wgt_addr  = wgtAddr;
    assign bus.out_valid = outValid;
    assign bus.out_data  = outData;
    assign bus.out_idx   = neuron;

endmodule

// File: tb/tb_mac_layer_sequencer.sv
// Bench for mac_layer_sequencer: buffer + mac environment, table vectors, directed corners, random layers.
`timescale 1ns/1ps
module tb_mac_layer_sequencer;
    import mac_seq_pkg::*;

    localparam int NC_A  = 2;
    localparam int NN_A  = 3;
    localparam int LAT_A = 1;
    localparam int NC_B  = 1;
    localparam int NN_B  = 1;
    localparam int LAT_B = 2;
    localparam int PER_A = NC_A + LAT_A + 2;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic startA = 1'b0, busyA, doneA, readyA = 1'b0;
    logic startB = 1'b0, busyB, doneB, readyB = 1'b0;

    always #5 clk = ~clk;

    mac_layer_sequencer_if #(.NUM_CHUNKS(NC_A), .NUM_NEURONS(NN_A), .ACC_W(24)) ifA ();
    mac_layer_sequencer_if #(.NUM_CHUNKS(NC_B), .NUM_NEURONS(NN_B), .ACC_W(24)) ifB ();

    mac_layer_sequencer #(
        .NUM_CHUNKS(NC_A), .NUM_NEURONS(NN_A), .MAC_LAT(LAT_A), .ACC_W(24), .RELU(1'b1)
    ) dutA (
        .clk(clk), .rst(rst), .start(startA), .busy(busyA), .done(doneA), .bus(ifA)
    );

    mac_layer_sequencer #(
        .NUM_CHUNKS(NC_B), .NUM_NEURONS(NN_B), .MAC_LAT(LAT_B), .ACC_W(24), .RELU(1'b0)
    ) dutB (
        .clk(clk), .rst(rst), .start(startB), .busy(busyB), .done(doneB), .bus(ifB)
    );

    // Environment: pixel/weight buffers (1-cycle read) feeding a mac with LAT register stages.
    byte pixA [NC_A][LANES];
    byte wgtA [NC_A*NN_A][LANES];
    byte pixB [LANES];
    byte wgtB [LANES];
    logic signed [SUM_W-1:0] macA [0:LAT_A] = '{default: '0};
    logic signed [SUM_W-1:0] macB [0:LAT_B] = '{default: '0};

    function automatic int dotA(input int c, input int wa);
        int s = 0;
        if (c < NC_A && wa < NC_A*NN_A)
            for (int l = 0; l < LANES; l++) s += int'(pixA[c][l]) * int'(wgtA[wa][l]);
        return s;
    endfunction

    function automatic int dotB();
        int s = 0;
        for (int l = 0; l < LANES; l++) s += int'(pixB[l]) * int'(wgtB[l]);
        return s;
    endfunction

    always @(posedge clk) begin
        if (ifA.rd_en) macA[0] <= SUM_W'(dotA(int'(ifA.pix_addr), int'(ifA.wgt_addr)));
        for (int k = 1; k <= LAT_A; k++) macA[k] <= macA[k-1];
        if (ifB.rd_en) macB[0] <= SUM_W'(dotB());
        for (int k = 1; k <= LAT_B; k++) macB[k] <= macB[k-1];
    end

    assign ifA.sum_in    = macA[LAT_A];
    assign ifB.sum_in    = macB[LAT_B];
    assign ifA.out_ready = readyA;
    assign ifB.out_ready = readyB;

    // Reference: neuron n = sum over all chunks and lanes of pixel*weight, wrapped to 24 bits, ReLU.
    function automatic logic [23:0] expectA(input int n);
        longint s = 0;
        logic signed [23:0] w;
        for (int c = 0; c < NC_A; c++)
            for (int l = 0; l < LANES; l++)
                s += longint'(pixA[c][l]) * longint'(wgtA[n*NC_A + c][l]);
        w = 24'(s);
        return (w < 0) ? 24'h0 : w;
    endfunction

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    typedef struct {
        int          p;
        int          w;
        logic [23:0] exp;
    } vec_t;
    vec_t tbl [6];

    int          gotIdx [$];
    logic [23:0] gotData [$];
    int          gotWgt [$];
    int          gotPix [$];
    int          riseEdge [$];
    int          doneEdge;
    int          doneCnt;
    int          badRd;

    task automatic fillConst(input int p, input int w);
        for (int c = 0; c < NC_A; c++) for (int l = 0; l < LANES; l++) pixA[c][l] = byte'(p);
        for (int a = 0; a < NC_A*NN_A; a++) for (int l = 0; l < LANES; l++) wgtA[a][l] = byte'(w);
    endtask

    task automatic fillRandom();
        for (int c = 0; c < NC_A; c++) for (int l = 0; l < LANES; l++) pixA[c][l] = byte'($urandom_range(0, 255));
        for (int a = 0; a < NC_A*NN_A; a++) for (int l = 0; l < LANES; l++) wgtA[a][l] = byte'($urandom_range(0, 255));
    endtask

    // Caller raises startA in the cycle before edge 0. mode: 0 ready high, 1 random ready, 2 hold neuron 1 for 5 cycles.
    task automatic runA(input int mode, input bit pokeStart);
        int cyc = 0;
        int hold = 0;
        bit prevValid = 0;
        bit checkResume = 0;
        bit fin = 0;
        gotIdx.delete(); gotData.delete(); gotWgt.delete(); gotPix.delete(); riseEdge.delete();
        doneEdge = -1; doneCnt = 0; badRd = 0;
        while (!fin && cyc < 300) begin
            @(negedge clk);
            cyc++;
            startA = pokeStart && (cyc == 1);
            if (checkResume) begin
                chk("resume rd_en", ifA.rd_en, 1);
                chk("resume wgt_addr", ifA.wgt_addr, 2*NC_A);
                checkResume = 0;
            end
            if (doneA) begin
                doneCnt++;
                doneEdge = cyc - 1;
                chk("busy low with done", busyA, 0);
                fin = 1;
            end
            if (ifA.rd_en) begin
                gotWgt.push_back(int'(ifA.wgt_addr));
                gotPix.push_back(int'(ifA.pix_addr));
                if (ifA.out_valid) badRd++;
            end
            if (ifA.out_valid && !prevValid) riseEdge.push_back(cyc - 1);
            prevValid = ifA.out_valid;
            case (mode)
                1: readyA = ($urandom_range(0, 2) != 0);
                2: begin
                    if (ifA.out_valid && ifA.out_idx == 1 && hold < 5) begin
                        readyA = 1'b0;
                        hold++;
                        chk("bp out_data", $unsigned(ifA.out_data), expectA(1));
                        chk("bp out_idx", ifA.out_idx, 1);
                        chk("bp rd_en low", ifA.rd_en, 0);
                    end else begin
                        readyA = 1'b1;
                    end
                end
                default: readyA = 1'b1;
            endcase
            if (ifA.out_valid && readyA) begin
                gotIdx.push_back(int'(ifA.out_idx));
                gotData.push_back($unsigned(ifA.out_data));
                if (mode == 2 && ifA.out_idx == 1) checkResume = 1;
            end
        end
        chk("layer completed", fin, 1);
        repeat (2) begin
            @(negedge clk);
            if (doneA) doneCnt++;
        end
        readyA = 1'b0;
    endtask

    task automatic verifyA(input string tag);
        int n;
        chk({tag, " result count"}, gotIdx.size(), NN_A);
        n = (gotIdx.size() < NN_A) ? gotIdx.size() : NN_A;
        for (int i = 0; i < n; i++) begin
            chk({tag, " out_idx"}, gotIdx[i], i);
            chk({tag, " out_data"}, gotData[i], expectA(i));
        end
        chk({tag, " read count"}, gotWgt.size(), NN_A*NC_A);
        n = (gotWgt.size() < NN_A*NC_A) ? gotWgt.size() : NN_A*NC_A;
        for (int i = 0; i < n; i++) begin
            chk({tag, " wgt_addr"}, gotWgt[i], i);
            chk({tag, " pix_addr"}, gotPix[i], i % NC_A);
        end
        chk({tag, " done pulses"}, doneCnt, 1);
        chk({tag, " reads while valid"}, badRd, 0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int cyc;
        bit seenB;
        tbl[0] = '{1, 1, 24'h000020};
        tbl[1] = '{-1, 1, 24'h000000};
        tbl[2] = '{127, 127, 24'h07E020};
        tbl[3] = '{-128, -128, 24'h080000};
        tbl[4] = '{-128, 127, 24'h000000};
        tbl[5] = '{7, 9, 24'h0007E0};
        fillConst(0, 0);
        for (int l = 0; l < LANES; l++) begin pixB[l] = 0; wgtB[l] = 0; end

        // Asynchronous reset, checked before any clock edge.
        #1 rst = 1'b1;
        #3;
        chk("reset busy", busyA, 0);
        chk("reset done", doneA, 0);
        chk("reset rd_en", ifA.rd_en, 0);
        chk("reset out_valid", ifA.out_valid, 0);
        chk("reset pix_addr", ifA.pix_addr, 0);
        chk("reset wgt_addr", ifA.wgt_addr, 0);
        chk("reset out_data", $unsigned(ifA.out_data), 0);
        chk("reset out_idx", ifA.out_idx, 0);
        chk("reset B busy", busyB, 0);
        repeat (2) @(negedge clk);
        rst = 1'b0;

        // Worked dot product, cycle timing, multi-neuron order, ReLU clamp.
        fillConst(0, 0);
        pixA[0][0] = 8'h56; wgtA[0][0] = 8'h32;
        pixA[0][13] = 8'h37; wgtA[0][13] = 8'h48;
        pixA[1][0] = 8'h12; wgtA[1][0] = 8'h34;
        wgtA[2][13] = 8'h01;
        pixA[0][5] = 8'h80; wgtA[4][5] = 8'h7F;
        @(negedge clk); startA = 1'b1;
        runA(0, 0);
        verifyA("sum");
        if (gotData.size() == NN_A) begin
            chk("sum neuron0", gotData[0], 24'h0023EC);
            chk("sum neuron1", gotData[1], 24'h000037);
            chk("relu clamp", gotData[2], 24'h000000);
        end else chk("sum result queue", gotData.size(), NN_A);
        chk("valid rise count", riseEdge.size(), NN_A);
        for (int i = 0; i < riseEdge.size() && i < NN_A; i++)
            chk("valid rise edge", riseEdge[i], NC_A + LAT_A + 1 + i*PER_A);
        chk("done edge", doneEdge, NN_A*PER_A);

        // Backpressure on neuron 1.
        fillRandom();
        @(negedge clk); startA = 1'b1;
        runA(2, 0);
        verifyA("backpressure");

        // start pulsed during ISSUE must not perturb the layer.
        fillRandom();
        @(negedge clk); startA = 1'b1;
        runA(0, 1);
        verifyA("start in ISSUE");
        chk("start in ISSUE done edge", doneEdge, NN_A*PER_A);

        // Constant-fill vectors.
        for (int t = 0; t < 6; t++) begin
            fillConst(tbl[t].p, tbl[t].w);
            @(negedge clk); startA = 1'b1;
            runA(0, 0);
            for (int i = 0; i < gotData.size(); i++) chk("table out_data", gotData[i], tbl[t].exp);
            chk("table results", gotData.size(), NN_A);
        end

        // Reset with reads in flight, then a fresh layer over all-zero buffers.
        fillConst(3, 2);
        @(negedge clk); startA = 1'b1;
        @(negedge clk); startA = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("pre-reset busy", busyA, 1);
        chk("pre-reset rd_en", ifA.rd_en, 0);
        chk("pre-reset out_valid", ifA.out_valid, 0);
        #1 rst = 1'b1;
        #1;
        chk("abort busy", busyA, 0);
        chk("abort done", doneA, 0);
        fillConst(0, 0);
        #1 rst = 1'b0;
        startA = 1'b1;
        runA(0, 0);
        verifyA("post-reset");

        // Random layers with random backpressure.
        for (int r = 0; r < 6; r++) begin
            fillRandom();
            @(negedge clk); startA = 1'b1;
            runA(1, $urandom_range(0, 1) == 1);
            verifyA("random");
        end

        // Single chunk, ReLU disabled, deeper mac.
        pixB[0] = 8'h80; wgtB[0] = 8'h7F;
        @(negedge clk); startB = 1'b1; readyB = 1'b1;
        cyc = 0; seenB = 0;
        while (!doneB && cyc < 50) begin
            @(negedge clk);
            cyc++;
            startB = 1'b0;
            if (ifB.out_valid && !seenB) begin
                seenB = 1;
                chk("B out_data relu off", $unsigned(ifB.out_data), 24'hFFC080);
                chk("B valid edge", cyc - 1, NC_B + LAT_B + 1);
            end
        end
        chk("B saw result", seenB, 1);
        chk("B done", doneB, 1);
        readyB = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
